k12a_skip_ctrl: RTL and testbench

Parametrised successor to the single-bit skip flag. Suppresses the next 1..MAX_SKIP retired instructions when a selected ALU or flag condition, optionally inverted, holds. Sits beside the control unit: it takes the decoded skip operation, per-instruction retire strobes and interrupt save/restore requests, and drives the instruction-suppress signal. Adds multi-instruction skip, condition selection, and a shadow copy for interrupt entry and return.

---
 rtl/k12a_skip_ctrl_pkg.sv | 22 ++
 rtl/k12a_skip_ctrl.sv | 119 +++++++++++
 tb/tb_k12a_skip_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/k12a_skip_ctrl_pkg.sv
// rtl/k12a_skip_ctrl_pkg.sv - shared k12a skip-control types and default constants
//
// Purpose: skip operation encoding and default sizing shared by the control
//          unit, the skip controller and its testbench.
// Contents:
//    skip_op_t      3-bit skip operation requested by the decoded instruction
//    K12A_NUM_COND  default number of condition inputs
//    K12A_MAX_SKIP  default largest skip count
package k12a_skip_ctrl_pkg;

   typedef enum logic [2:0] {
      SKIP_OP_HOLD   = 3'd0,
      SKIP_OP_CLEAR  = 3'd1,
      SKIP_OP_COND   = 3'd2,
      SKIP_OP_COND_N = 3'd3,
      SKIP_OP_ALWAYS = 3'd4
   } skip_op_t;

   localparam int K12A_NUM_COND = 4;
   localparam int K12A_MAX_SKIP = 3;

endpackage

// File: rtl/k12a_skip_ctrl.sv
// rtl/k12a_skip_ctrl.sv - multi-instruction conditional skip controller with interrupt shadow
//
// Purpose: suppresses the next 1..MAX_SKIP retired instructions when a selected
//          condition (optionally inverted) holds; keeps a shadow copy of the
//          live count for interrupt entry and return.
// Ports:
//    cpu_clock       in   single clock, rising-edge state updates
//    reset_n         in   asynchronous active-low reset
//    cond            in   condition vector (bit 0 = alu_condition)
//    cond_idx        in   selects the predicate bit; out-of-range reads as 0
//    skip_op         in   requested skip operation, qualified by insn_retire
//    skip_len        in   number of following instructions to skip
//    insn_retire     in   current instruction completes this cycle
//    flush           in   clear live skip state
//    shadow_save     in   copy post-update count into shadow
//    shadow_restore  in   copy shadow into count
//    skip            out  current instruction is suppressed
//    skip_remaining  out  live count, including the current instruction
module k12a_skip_ctrl
   import k12a_skip_ctrl_pkg::*;
#(
   parameter int NUM_COND = K12A_NUM_COND,
   parameter int MAX_SKIP = K12A_MAX_SKIP,
   localparam int CNT_W = $clog2(MAX_SKIP + 1),
   localparam int SEL_W = (NUM_COND > 1) ? $clog2(NUM_COND) : 1
) (
   input  logic                cpu_clock,
   input  logic                reset_n,
   input  logic [NUM_COND-1:0] cond,
   input  logic [SEL_W-1:0]    cond_idx,
   input  skip_op_t            skip_op,
   input  logic [CNT_W-1:0]    skip_len,
   input  logic                insn_retire,
   input  logic                flush,
   input  logic                shadow_save,
   input  logic                shadow_restore,
   output logic                skip,
   output logic [CNT_W-1:0]    skip_remaining
);

   // Condition vector padded to every value cond_idx can take; the padding
   // bits are zero so an out-of-range index yields a false predicate.
   localparam int               COND_EXT_W = 1 << SEL_W;
   localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_SKIP);

   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      shadow;
   logic [CNT_W-1:0]      count_next;
   logic [CNT_W-1:0]      shadow_next;
   logic [COND_EXT_W-1:0] cond_ext;
   logic                  predicate;
   logic [CNT_W-1:0]      eff_len;
   logic                  set_valid;
   logic                  set_hit;
   logic [CNT_W-1:0]      set_value;

   assign cond_ext  = COND_EXT_W'(cond);
   assign predicate = cond_ext[cond_idx];
   assign eff_len   = (skip_len > MAX_CNT) ? MAX_CNT : skip_len;

   // Only an executed (non-suppressed) retiring instruction may set the count.
   assign set_valid = insn_retire && (count == '0);

   always_comb begin
      set_hit   = 1'b0;
      set_value = eff_len;
      case (skip_op)
         SKIP_OP_CLEAR: begin
            set_hit   = 1'b1;
            set_value = '0;
         end
         SKIP_OP_COND:   set_hit = predicate;
         SKIP_OP_COND_N: set_hit = !predicate;
         SKIP_OP_ALWAYS: set_hit = 1'b1;
         default:        set_hit = 1'b0;
      endcase
   end

   always_comb begin
      count_next = count;
      if (flush) begin
         count_next = '0;
      end else if (shadow_restore) begin
         count_next = shadow;
      end else if (set_valid && set_hit) begin
         count_next = set_value;
      end else if (insn_retire && (count != '0)) begin
         count_next = count - CNT_W'(1);
      end
   end

   // Restore wins over save: a simultaneous save/restore leaves shadow as is.
   always_comb begin
      shadow_next = shadow;
      if (shadow_save && !shadow_restore) begin
         shadow_next = count_next;
      end
   end

   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) begin
         count  <= '0;
         shadow <= '0;
      end else begin
         count  <= count_next;
         shadow <= shadow_next;
      end
   end

   assign skip           = (count != '0);
   assign skip_remaining = count;

   a_skip_op_legal : assert property (
      @(posedge cpu_clock) disable iff (!reset_n)
      insn_retire |-> (skip_op inside {SKIP_OP_HOLD, SKIP_OP_CLEAR, SKIP_OP_COND,
                                       SKIP_OP_COND_N, SKIP_OP_ALWAYS})
   );

endmodule

// File: tb/tb_k12a_skip_ctrl.sv
// tb/tb_k12a_skip_ctrl.sv - self-checking bench for k12a_skip_ctrl
module tb_k12a_skip_ctrl;
   import k12a_skip_ctrl_pkg::*;

   logic       cpu_clock = 1'b0;
   logic       reset_n;
   logic [3:0] cond;
   logic [1:0] idx;
   skip_op_t   op;
   logic [2:0] len;
   logic       retire;
   logic       flush;
   logic       save;
   logic       restore;

   logic       skip_a;
   logic [1:0] rem_a;
   logic       skip_b;
   logic [2:0] rem_b;

   int checks = 0;
   int errors = 0;

   // Reference state: instance A (4 conditions, max 3), instance B (3 conditions, max 5)
   int ma_cnt, ma_sh, mb_cnt, mb_sh;

   always #5 cpu_clock = ~cpu_clock;

   k12a_skip_ctrl #(.NUM_COND(4), .MAX_SKIP(3)) dut (
      .cpu_clock(cpu_clock), .reset_n(reset_n), .cond(cond), .cond_idx(idx),
      .skip_op(op), .skip_len(len[1:0]), .insn_retire(retire), .flush(flush),
      .shadow_save(save), .shadow_restore(restore),
      .skip(skip_a), .skip_remaining(rem_a)
   );

   k12a_skip_ctrl #(.NUM_COND(3), .MAX_SKIP(5)) dut_b (
      .cpu_clock(cpu_clock), .reset_n(reset_n), .cond(cond[2:0]), .cond_idx(idx),
      .skip_op(op), .skip_len(len), .insn_retire(retire), .flush(flush),
      .shadow_save(save), .shadow_restore(restore),
      .skip(skip_b), .skip_remaining(rem_b)
   );

   // Next live count from the rules: flush, restore, set by an executed
   // instruction, decrement on retire, else hold.
   function automatic int ref_next(int cnt, int sh, int nc, int mx, int lenmask);
      int  l;
      bit  p;
      bit  sets;
      l = int'(len) & lenmask;
      if (l > mx) l = mx;
      p = (int'(idx) < nc) ? cond[idx] : 1'b0;
      sets = (op == SKIP_OP_ALWAYS) || (op == SKIP_OP_CLEAR) ||
             (op == SKIP_OP_COND && p) || (op == SKIP_OP_COND_N && !p);
      if (flush) return 0;
      if (restore) return sh;
      if (retire && cnt == 0 && sets) return (op == SKIP_OP_CLEAR) ? 0 : l;
      if (retire && cnt > 0) return cnt - 1;
      return cnt;
   endfunction

   task automatic tick();
      int na, nb;
      if (reset_n) begin
         na = ref_next(ma_cnt, ma_sh, 4, 3, 3);
         nb = ref_next(mb_cnt, mb_sh, 3, 5, 7);
         if (save && !restore) begin
            ma_sh = na;
            mb_sh = nb;
         end
         ma_cnt = na;
         mb_cnt = nb;
      end
      @(posedge cpu_clock);
      #1;
   endtask

   task automatic idle();
      op = SKIP_OP_HOLD; retire = 1'b0; flush = 1'b0; save = 1'b0; restore = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (skip_a !== 1'b0 || rem_a !== 2'd0) begin
         errors++; $display("FAIL reset_state got skip=%b rem=%0d want 0/0", skip_a, rem_a);
      end
      checks++;
      if (skip_b !== 1'b0 || rem_b !== 3'd0) begin
         errors++; $display("FAIL reset_state_b got skip=%b rem=%0d want 0/0", skip_b, rem_b);
      end
   endtask

   task automatic test_cond_countdown();
      cond = 4'b0001; idx = 2'd0; len = 3'd2; op = SKIP_OP_COND; retire = 1'b1;
      tick();
      checks++;
      if (skip_a !== 1'b1 || rem_a !== 2'd2) begin
         errors++; $display("FAIL cond_set got skip=%b rem=%0d want 1/2", skip_a, rem_a);
      end
      checks++;
      if (rem_b !== 3'd2) begin
         errors++; $display("FAIL cond_set_b got rem=%0d want 2", rem_b);
      end
      op = SKIP_OP_HOLD;
      tick();
      checks++;
      if (rem_a !== 2'd1) begin
         errors++; $display("FAIL cond_dec1 got rem=%0d want 1", rem_a);
      end
      tick();
      checks++;
      if (skip_a !== 1'b0 || rem_a !== 2'd0) begin
         errors++; $display("FAIL cond_dec0 got skip=%b rem=%0d want 0/0", skip_a, rem_a);
      end
      idle();
   endtask

   task automatic test_cond_n_clamp_idx();
      cond = 4'b0001; idx = 2'd0; len = 3'd2; op = SKIP_OP_COND_N; retire = 1'b1;
      tick();
      checks++;
      if (skip_a !== 1'b0 || rem_b !== 3'd0) begin
         errors++; $display("FAIL cond_n_true got skip=%b rem_b=%0d want 0/0", skip_a, rem_b);
      end
      op = SKIP_OP_ALWAYS; len = 3'd7;
      tick();
      checks++;
      if (rem_a !== 2'd3) begin
         errors++; $display("FAIL always_len_a got rem=%0d want 3", rem_a);
      end
      checks++;
      if (rem_b !== 3'd5) begin
         errors++; $display("FAIL always_clamp_b got rem=%0d want 5", rem_b);
      end
      idle(); flush = 1'b1;
      tick();
      cond = 4'b1000; idx = 2'd3; len = 3'd7; op = SKIP_OP_COND; retire = 1'b1; flush = 1'b0;
      tick();
      checks++;
      if (rem_a !== 2'd3) begin
         errors++; $display("FAIL idx3_in_range got rem=%0d want 3", rem_a);
      end
      checks++;
      if (skip_b !== 1'b0 || rem_b !== 3'd0) begin
         errors++; $display("FAIL idx_out_of_range got skip=%b rem=%0d want 0/0", skip_b, rem_b);
      end
      idle(); flush = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_suppressed_set_multicycle();
      op = SKIP_OP_ALWAYS; len = 3'd2; retire = 1'b1;
      tick();
      len = 3'd3;
      tick();
      checks++;
      if (rem_a !== 2'd1 || rem_b !== 3'd1) begin
         errors++; $display("FAIL suppressed_set got rem_a=%0d rem_b=%0d want 1/1", rem_a, rem_b);
      end
      op = SKIP_OP_ALWAYS; retire = 1'b0;
      tick();
      tick();
      checks++;
      if (skip_a !== 1'b1 || rem_a !== 2'd1) begin
         errors++; $display("FAIL multicycle_hold got skip=%b rem=%0d want 1/1", skip_a, rem_a);
      end
      op = SKIP_OP_HOLD; retire = 1'b1;
      tick();
      checks++;
      if (skip_a !== 1'b0 || rem_a !== 2'd0) begin
         errors++; $display("FAIL multicycle_drop got skip=%b rem=%0d want 0/0", skip_a, rem_a);
      end
      idle();
   endtask

   task automatic test_shadow();
      op = SKIP_OP_ALWAYS; len = 3'd2; retire = 1'b1;
      tick();
      idle(); save = 1'b1;
      tick();
      save = 1'b0; flush = 1'b1;
      tick();
      checks++;
      if (rem_a !== 2'd0) begin
         errors++; $display("FAIL shadow_flush got rem=%0d want 0", rem_a);
      end
      flush = 1'b0; restore = 1'b1;
      tick();
      checks++;
      if (rem_a !== 2'd2 || rem_b !== 3'd2) begin
         errors++; $display("FAIL shadow_restore got rem_a=%0d rem_b=%0d want 2/2", rem_a, rem_b);
      end
      restore = 1'b0; retire = 1'b1;
      tick();
      retire = 1'b0; save = 1'b1; restore = 1'b1;
      tick();
      checks++;
      if (rem_a !== 2'd2) begin
         errors++; $display("FAIL save_restore_same got rem=%0d want 2", rem_a);
      end
      save = 1'b0; restore = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0; restore = 1'b1;
      tick();
      checks++;
      if (rem_a !== 2'd2) begin
         errors++; $display("FAIL shadow_unchanged got rem=%0d want 2", rem_a);
      end
      idle();
   endtask

   task automatic test_flush_priority();
      flush = 1'b1; op = SKIP_OP_ALWAYS; len = 3'd3; retire = 1'b1;
      tick();
      checks++;
      if (skip_a !== 1'b0 || rem_a !== 2'd0 || rem_b !== 3'd0) begin
         errors++; $display("FAIL flush_priority got skip=%b rem_a=%0d rem_b=%0d want 0/0/0", skip_a, rem_a, rem_b);
      end
      flush = 1'b0;
      tick();
      checks++;
      if (rem_a !== 2'd3) begin
         errors++; $display("FAIL set_after_flush got rem=%0d want 3", rem_a);
      end
      idle(); flush = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_reset_mid_skip();
      op = SKIP_OP_ALWAYS; len = 3'd3; retire = 1'b1; save = 1'b1;
      tick();
      idle();
      checks++;
      if (rem_a !== 2'd3) begin
         errors++; $display("FAIL preload got rem=%0d want 3", rem_a);
      end
      #2 reset_n = 1'b0;
      ma_cnt = 0; ma_sh = 0; mb_cnt = 0; mb_sh = 0;
      #1;
      checks++;
      if (skip_a !== 1'b0 || rem_a !== 2'd0 || skip_b !== 1'b0 || rem_b !== 3'd0) begin
         errors++; $display("FAIL async_reset got skip=%b rem=%0d want 0/0", skip_a, rem_a);
      end
      #2 reset_n = 1'b1;
      restore = 1'b1;
      tick();
      checks++;
      if (rem_a !== 2'd0) begin
         errors++; $display("FAIL shadow_after_reset got rem=%0d want 0", rem_a);
      end
      idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         cond    = 4'($urandom);
         idx     = 2'($urandom);
         len     = 3'($urandom);
         op      = skip_op_t'($urandom_range(0, 4));
         retire  = ($urandom_range(0, 3) != 0);
         flush   = ($urandom_range(0, 19) == 0);
         save    = ($urandom_range(0, 9) == 0);
         restore = ($urandom_range(0, 11) == 0);
         tick();
         checks++;
         if (rem_a !== 2'(ma_cnt) || skip_a !== (ma_cnt != 0)) begin
            errors++; $display("FAIL random_a iter %0d got skip=%b rem=%0d want rem=%0d", i, skip_a, rem_a, ma_cnt);
         end
         checks++;
         if (rem_b !== 3'(mb_cnt) || skip_b !== (mb_cnt != 0)) begin
            errors++; $display("FAIL random_b iter %0d got skip=%b rem=%0d want rem=%0d", i, skip_b, rem_b, mb_cnt);
         end
      end
      idle();
   endtask

   initial begin
      reset_n = 1'b0;
      cond = '0; idx = '0; len = '0;
      ma_cnt = 0; ma_sh = 0; mb_cnt = 0; mb_sh = 0;
      idle();
      #2;
      test_reset();
      #1 reset_n = 1'b1;
      test_cond_countdown();
      test_cond_n_clamp_idx();
      test_suppressed_set_multicycle();
      test_shadow();
      test_flush_priority();
      test_reset_mid_skip();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
